// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: controls a bit-serial N-bit adder built from one 1-bit full adder.
// The adder consumes one bit per clock, LSB first. The N-bit sum and the carry-out
// are returned on a valid/ready handshake.
// Optional feature macro: SERIAL_ADD_CTRL_SUB_EN. When it is defined, a 'sub' input
// selects x - y, implemented as x + ~y + 1.
module serial_add_ctrl #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_valid,
  output logic         start_ready,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         c0,
`ifdef SERIAL_ADD_CTRL_SUB_EN
  input  logic         sub,
`endif
  output logic         done_valid,
  input  logic         done_ready,
  output logic [N-1:0] s,
  output logic         c_out,
  output logic         busy
);

  // The counter has one spare bit. This keeps CW non-zero when N = 1.
  localparam int            CW       = $clog2(N) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    xa_q, xa_d;
  logic [N-1:0]    ya_q, ya_d;
  logic [N-1:0]    s_q, s_d;
  logic            carry_q, carry_d;
  logic            cout_q, cout_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  // Values captured on the accept edge.
  logic [N-1:0]    ld_y;
  logic            ld_c;

  // Outputs of the single full-adder cell.
  logic            fa_sum;
  logic            fa_cry;

  // Select the operand B and carry-in to load. Subtraction loads ~y and forces a carry-in of 1.
  always_comb begin
`ifdef SERIAL_ADD_CTRL_SUB_EN
    ld_y = sub ? ~y : y;
    ld_c = sub ? 1'b1 : c0;
`else
    ld_y = y;
    ld_c = c0;
`endif
  end

  // Full-adder cell. It always sees the current LSBs of the operand shift registers.
  always_comb begin
    fa_sum = xa_q[0] ^ ya_q[0] ^ carry_q;
    fa_cry = (xa_q[0] & ya_q[0]) | (xa_q[0] & carry_q) | (ya_q[0] & carry_q);
  end

  // Next-state and datapath update. Every register holds unless its state says otherwise.
  always_comb begin
    state_d = state_q;
    xa_d    = xa_q;
    ya_d    = ya_q;
    s_d     = s_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (start_valid) begin
          xa_d    = x;
          ya_d    = ld_y;
          carry_d = ld_c;
          cnt_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        // Shift in one sum bit at the MSB per clock. After N steps bit 0 is the LSB of the sum.
        xa_d       = xa_q >> 1;
        ya_d       = ya_q >> 1;
        s_d        = s_q >> 1;
        s_d[N-1]   = fa_sum;
        carry_d    = fa_cry;
        cnt_d      = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          cout_d  = fa_cry;
          state_d = DONE;
        end
      end

      DONE: begin
        // Hold the result until the consumer takes it. New requests are ignored here.
        if (done_ready) state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register. Reset takes priority over both handshakes and discards any result in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      xa_q    <= '0;
      ya_q    <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      xa_q    <= xa_d;
      ya_q    <= ya_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  // All handshake outputs decode directly from the state register.
  always_comb begin
    start_ready = (state_q == IDLE);
    done_valid  = (state_q == DONE);
    busy        = (state_q == RUN) || (state_q == DONE);
    s           = s_q;
    c_out       = cout_q;
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Testbench for serial_add_ctrl. N=3 main instance plus an N=1 instance.
module tb_serial_add_ctrl;
  localparam int N = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_valid, start_ready, c0, done_valid, done_ready, c_out, busy;
  logic [N-1:0] x, y, s;
`ifdef SERIAL_ADD_CTRL_SUB_EN
  logic         sub;
  logic         sub1;
`endif

  // N=1 instance signals
  logic         sv1, sr1, c01, dv1, dr1, co1, bz1;
  logic [0:0]   x1, y1, s1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.N(N)) dut (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
    .x(x), .y(y), .c0(c0),
`ifdef SERIAL_ADD_CTRL_SUB_EN
    .sub(sub),
`endif
    .done_valid(done_valid), .done_ready(done_ready), .s(s), .c_out(c_out), .busy(busy)
  );

  serial_add_ctrl #(.N(1)) dut1 (
    .clk(clk), .rst(rst), .start_valid(sv1), .start_ready(sr1),
    .x(x1), .y(y1), .c0(c01),
`ifdef SERIAL_ADD_CTRL_SUB_EN
    .sub(sub1),
`endif
    .done_valid(dv1), .done_ready(dr1), .s(s1), .c_out(co1), .busy(bz1)
  );

  // Reference: plain arithmetic on the operands
  function automatic logic [N:0] model(input logic [N-1:0] a, input logic [N-1:0] b,
                                       input logic ci, input logic sb);
    logic [N-1:0] diff;
    if (sb) begin
      diff = a - b;
      return {(a >= b), diff};
    end
    return {1'b0, a} + {1'b0, b} + {{N{1'b0}}, ci};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Runs one operation. Holds done_ready low for 'hold' cycles after completion.
  // If pulse is set, start_valid is pulsed during the hold to show it is ignored.
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic ci,
                        input logic sb, input int hold, input bit pulse, input string tag);
    logic [N:0] e;
    int cyc;
    e = model(a, b, ci, sb);
    chk({tag, ":ready"}, 64'(start_ready), 64'd1);
    x = a; y = b; c0 = ci;
`ifdef SERIAL_ADD_CTRL_SUB_EN
    sub = sb;
`endif
    start_valid = 1'b1;
    done_ready  = 1'b0;
    tick;
    start_valid = 1'b0;
    x = ~a; y = ~b; c0 = ~ci;
    chk({tag, ":run_busy"}, {62'd0, busy, start_ready}, 64'b10);
    cyc = 0;
    while (done_valid !== 1'b1 && cyc < 4 * N + 8) begin
      tick;
      cyc++;
    end
    chk({tag, ":latency"}, 64'(cyc), 64'(N));
    chk({tag, ":sum"}, {63'd0, c_out, s}, {63'd0, e});
    for (int i = 0; i < hold; i++) begin
      if (pulse) begin
        start_valid = i[0];
        x = 3'b101; y = 3'b001;
      end
      tick;
      chk({tag, ":hold"}, {60'd0, start_ready, done_valid, c_out, s}, {60'd0, 2'b01, e});
    end
    start_valid = 1'b0;
    done_ready  = 1'b1;
    tick;
    done_ready  = 1'b0;
    chk({tag, ":release"}, {60'd0, start_ready, done_valid, busy, c_out, s},
        {60'd0, 3'b100, e});
    if (pulse) begin
      tick;
      chk({tag, ":no_accept"}, {62'd0, start_ready, busy}, 64'b10);
    end
  endtask

  initial begin
    logic [N-1:0] ra, rb;
    logic rc, rs;
    rst = 1'b1; start_valid = 1'b0; done_ready = 1'b0; x = '0; y = '0; c0 = 1'b0;
    sv1 = 1'b0; dr1 = 1'b0; x1 = 1'b0; y1 = 1'b0; c01 = 1'b0;
`ifdef SERIAL_ADD_CTRL_SUB_EN
    sub = 1'b0; sub1 = 1'b0;
`endif
    tick; tick;
    rst = 1'b0;
    chk("reset", {59'd0, start_ready, done_valid, busy, c_out, s}, {59'd0, 3'b100, 1'b0, 3'b000});

    // N=1: exactly one RUN cycle
    x1 = 1'b1; y1 = 1'b1; c01 = 1'b1; sv1 = 1'b1;
    tick;
    sv1 = 1'b0;
    chk("n1_run", {62'd0, dv1, bz1}, 64'b01);
    tick;
    chk("n1_done", {61'd0, dv1, co1, s1}, 64'b111);
    dr1 = 1'b1;
    tick;
    dr1 = 1'b0;
    chk("n1_idle", {62'd0, sr1, dv1}, 64'b10);

    // Directed cases
    run_op(3'b011, 3'b010, 1'b0, 1'b0, 0, 1'b0, "d_011_010");
    chk("d1_exact", {60'd0, c_out, s}, 64'b0101);
    run_op(3'b111, 3'b111, 1'b0, 1'b0, 0, 1'b0, "d_111_111");
    chk("d2_exact", {60'd0, c_out, s}, 64'b1110);
    run_op(3'b001, 3'b001, 1'b1, 1'b0, 0, 1'b0, "d_001_001_c");
    chk("d3_exact", {60'd0, c_out, s}, 64'b0011);
    run_op(3'b110, 3'b011, 1'b1, 1'b0, 5, 1'b1, "d_hold");

    // Reset on the second RUN cycle
    x = 3'b111; y = 3'b111; c0 = 1'b1; start_valid = 1'b1;
    tick;
    start_valid = 1'b0;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("rst_run", {59'd0, start_ready, done_valid, busy, c_out, s}, {59'd0, 3'b100, 1'b0, 3'b000});
    tick; tick; tick;
    chk("rst_run_quiet", {62'd0, done_valid, busy}, 64'b00);
    run_op(3'b010, 3'b001, 1'b0, 1'b0, 0, 1'b0, "after_rst");
    chk("after_rst_exact", {60'd0, c_out, s}, 64'b0011);

    // Reset while in DONE with done_ready held low
    x = 3'b111; y = 3'b001; c0 = 1'b0; start_valid = 1'b1;
    tick;
    start_valid = 1'b0;
    repeat (N) tick;
    chk("pre_rst_done", 64'(done_valid), 64'd1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("rst_done", {59'd0, start_ready, done_valid, busy, c_out, s}, {59'd0, 3'b100, 1'b0, 3'b000});

`ifdef SERIAL_ADD_CTRL_SUB_EN
    run_op(3'b011, 3'b010, 1'b0, 1'b1, 0, 1'b0, "sub_011_010");
    chk("sub1_exact", {60'd0, c_out, s}, 64'b1001);
    run_op(3'b010, 3'b011, 1'b1, 1'b1, 0, 1'b0, "sub_010_011");
    chk("sub2_exact", {60'd0, c_out, s}, 64'b0111);
`endif

    // Randomized operations
    for (int k = 0; k < 24; k++) begin
      ra = N'($urandom);
      rb = N'($urandom);
      rc = 1'($urandom);
      rs = 1'b0;
`ifdef SERIAL_ADD_CTRL_SUB_EN
      rs = 1'($urandom);
`endif
      run_op(ra, rb, rc, rs, int'($urandom_range(0, 3)), 1'b0, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
